// File: rtl/div_pkg.sv
// Shared definitions for the signed divider: default widths, FSM states and
// the iteration-counter sizing rule.
package div_pkg;

    localparam int DW_N_DEF = 26;
    localparam int DW_D_DEF = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Counter runs 0..n-1, one step per quotient bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DW_N_DEF);

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first,
// with a DW_D+1-bit partial remainder and its own iteration counter.
module div_core
    import div_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [DW_N-1:0] i_dvd,
    input  logic [DW_D-1:0] i_dvs,
    output logic            o_last,
    output logic [DW_N-1:0] o_quot,
    output logic [DW_D-1:0] o_rem
);

    localparam int CW = cnt_width(DW_N);

    logic [DW_N-1:0] r_q;
    logic [DW_D-1:0] r_d;
    logic [DW_D:0]   r_part;
    logic [CW-1:0]   r_cnt;

    logic [DW_D+1:0] w_shift;
    logic [DW_D+1:0] w_diff;
    logic            w_borrow;

    // Extra top bit on the trial subtraction acts as the borrow/sign.
    assign w_shift  = {r_part, r_q[DW_N-1]};
    assign w_diff   = w_shift - {2'b00, r_d};
    assign w_borrow = w_diff[DW_D+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_part <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_q    <= i_dvd;
            r_d    <= i_dvs;
            r_part <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_q    <= {r_q[DW_N-2:0], ~w_borrow};
            r_part <= w_borrow ? w_shift[DW_D:0] : w_diff[DW_D:0];
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_last = i_step && (r_cnt == CW'(DW_N-1));
    assign o_quot = r_q;
    assign o_rem  = r_part[DW_D-1:0];

endmodule

// File: rtl/signed_div.sv
// Multi-cycle signed divider: magnitudes go through div_core, signs and the
// divide-by-zero / overflow special cases are resolved here.
module signed_div
    import div_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [DW_N-1:0] din1,
    input  logic signed [DW_D-1:0] din2,
    output logic                   busy,
    output logic                   done,
    output logic signed [DW_N-1:0] quot,
    output logic signed [DW_D-1:0] rem,
    output logic                   dz,
    output logic                   ovf
);

    div_state_e r_state, w_next;

    logic            w_load, w_step, w_last;
    logic [DW_N-1:0] w_mag1, w_qmag;
    logic [DW_D-1:0] w_mag2, w_rmag;
    logic            w_is_dz, w_is_ovf;

    logic                   r_qneg, r_rneg, r_is_dz, r_is_ovf;
    logic signed [DW_N-1:0] r_quot;
    logic signed [DW_D-1:0] r_rem;
    logic                   r_dz, r_ovf;

    assign w_mag1   = din1[DW_N-1] ? -din1 : din1;
    assign w_mag2   = din2[DW_D-1] ? -din2 : din2;
    assign w_is_dz  = (din2 == '0);
    assign w_is_ovf = (din1 == {1'b1, {(DW_N-1){1'b0}}}) && (&din2);

    div_core #(.DW_N(DW_N), .DW_D(DW_D)) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_dvd  (w_mag1),
        .i_dvs  (w_mag2),
        .o_last (w_last),
        .o_quot (w_qmag),
        .o_rem  (w_rmag)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_next = CALC;
                w_load = 1'b1;
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) w_next = FIX;
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_dz  <= 1'b0;
            r_is_ovf <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_qneg   <= din1[DW_N-1] ^ din2[DW_D-1];
                r_rneg   <= din1[DW_N-1];
                r_is_dz  <= w_is_dz;
                r_is_ovf <= w_is_ovf;
            end
            // Overflow needs no special case: |min| wraps back to min.
            if (r_state == FIX) begin
                r_quot <= r_is_dz ? '0 : (r_qneg ? -w_qmag : w_qmag);
                r_rem  <= r_is_dz ? '0 : (r_rneg ? -w_rmag : w_rmag);
                r_dz   <= r_is_dz;
                r_ovf  <= r_is_ovf;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign quot = r_quot;
    assign rem  = r_rem;
    assign dz   = r_dz;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_signed_div.sv
// Directed bench for signed_div: hand-computed vectors, busy-start rejection
// and mid-run reset abort.
module tb_signed_div;

    localparam int DW_N = 26;
    localparam int DW_D = 13;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic signed [DW_N-1:0] din1;
    logic signed [DW_D-1:0] din2;
    logic                   busy, done, dz, ovf;
    logic signed [DW_N-1:0] quot;
    logic signed [DW_D-1:0] rem;

    int checks = 0;
    int errors = 0;

    signed_div #(.DW_N(DW_N), .DW_D(DW_D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din1  (din1),
        .din2  (din2),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .dz    (dz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".quot"}, quot, 0);
        chk({tag, ".rem"},  rem,  0);
        chk({tag, ".dz"},   dz,   0);
        chk({tag, ".ovf"},  ovf,  0);
    endtask

    // Issues one division and checks latency, results and the trailing idle.
    task automatic run(input string tag, input logic signed [63:0] a,
                       input logic signed [63:0] b, input logic signed [63:0] eq,
                       input logic signed [63:0] er, input logic edz, input logic eovf);
        int lat;
        din1  = a[DW_N-1:0];
        din2  = b[DW_D-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"},  lat,  27);
        chk({tag, ".quot"}, quot, eq);
        chk({tag, ".rem"},  rem,  er);
        chk({tag, ".dz"},   dz,   edz);
        chk({tag, ".ovf"},  ovf,  eovf);
        tick();
        chk({tag, ".done_fall"}, done, 0);
        chk({tag, ".busy_fall"}, busy, 0);
    endtask

    initial begin
        int ndone;
        rst   = 1'b0;
        start = 1'b0;
        din1  = '0;
        din2  = '0;
        tick();
        tick();
        chk_zero("reset");

        // start is already waiting when reset releases
        rst = 1'b1;
        run("p_p",   1000,  7,  142,  6, 1'b0, 1'b0);
        run("n_p",  -1000,  7, -142, -6, 1'b0, 1'b0);
        run("p_n",   1000, -7, -142,  6, 1'b0, 1'b0);
        run("n_n",  -1000, -7,  142, -6, 1'b0, 1'b0);
        run("dz",       5,  0,    0,  0, 1'b1, 1'b0);
        run("ovf", -33554432, -1, -33554432, 0, 1'b0, 1'b1);
        run("min_4096", -33554432, -4096, 8192, 0, 1'b0, 1'b0);
        run("zero_dvd",  0, -5,    0,  0, 1'b0, 1'b0);
        run("small",    -7, 1000,  0, -7, 1'b0, 1'b0);

        // start re-raised mid-run and during done, with fresh operands
        din1  = 1000;
        din2  = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            tick();
            if (c == 4) begin
                start = 1'b1;
                din1  = 50;
                din2  = 3;
            end
            if (c == 5) start = 1'b0;
            if (c == 26) chk("ign.early_done", done, 0);
            if (c == 27) begin
                chk("ign.done", done, 1);
                chk("ign.quot", quot, 142);
                chk("ign.rem",  rem,  6);
                start = 1'b1;
                din1  = 9;
                din2  = 2;
            end
        end
        tick();
        start = 1'b0;
        chk("ign.busy_fall", busy, 0);
        chk("ign.done_fall", done, 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("ign.extra_done", ndone, 0);
        chk("ign.hold_quot", quot, 142);
        chk("ign.hold_rem",  rem,  6);

        // reset pulled at cycle 10 of a run
        din1  = -1000;
        din2  = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b0;
        #1;
        chk_zero("abort");
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort.no_done", ndone, 0);
        chk("abort.idle", busy, 0);
        run("after_abort", -1000, -7, 142, -6, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/signed_div.md
SIGNED_DIV -- requirements
Module: signed_div

Interface
REQ-001 SHALL have parameter DW_N, default 26, meaning dividend/quotient width.
REQ-002 SHALL have parameter DW_D, default 13, meaning divisor/remainder width.
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-006 SHALL have port din1, input, DW_N signed, dividend.
REQ-007 SHALL have port din2, input, DW_D signed, divisor.
REQ-008 SHALL have port busy, output, 1, high from the accepting edge until done falls.
REQ-009 SHALL have port done, output, 1, single-cycle result-valid pulse.
REQ-010 SHALL have port quot, output, DW_N signed, quotient truncated toward zero.
REQ-011 SHALL have port rem, output, DW_D signed, remainder with the sign of din1.
REQ-012 SHALL have port dz, output, 1, divide-by-zero flag.
REQ-013 SHALL have port ovf, output, 1, quotient-overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after DW_N iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-015 SHALL latch din1, din2 on the accepting edge; later input changes SHALL have no effect.
REQ-016 SHALL convert operands to magnitudes (two's-complement negate if negative) and record result signs: quotient sign = sign(din1) XOR sign(din2), remainder sign = sign(din1).
REQ-017 SHALL perform unsigned restoring division, one quotient bit per clock, MSB first, with a DW_D+1-bit partial remainder.
REQ-018 SHALL apply result signs in FIX and register quot, rem, dz, ovf on the FIX->DONE edge.
REQ-019 SHALL raise done exactly DW_N+1 rising edges after the accepting edge (27 with defaults), for one cycle only.
REQ-020 SHALL hold quot, rem, dz, ovf stable from done until the next done.
REQ-021 SHALL ignore start while busy=1, including in the DONE cycle.
REQ-022 SHALL, when din2=0, run with the same latency and return quot=0, rem=0, dz=1, ovf=0.
REQ-023 SHALL, when din1=-2^(DW_N-1) and din2=-1, return quot=-2^(DW_N-1) (wrapped), rem=0, ovf=1, dz=0.
REQ-024 SHALL return dz=0 and ovf=0 for all other operand pairs.
REQ-025 SHALL return quot=0 and rem=0 when din1=0, regardless of signs.

Reset
REQ-026 SHALL, while rst=0, force state IDLE, busy=0, done=0, quot=0, rem=0, dz=0, ovf=0, and clear iteration counter and working registers.
REQ-027 SHALL abort any division in progress on reset, with no done pulse after release.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL place DW_N, DW_D defaults, the FSM state enum, and the iteration-count width in shared package div_pkg.
REQ-030 SHALL instantiate one sub-module, div_core, holding the unsigned shift/subtract datapath and iteration counter; sign handling, flags and FSM stay in signed_div.

Verification
REQ-031 SHALL cover: din1=1000, din2=7 -> quot=142, rem=6, dz=0, ovf=0, done 27 edges after start.
REQ-032 SHALL cover: (-1000,7) -> quot=-142, rem=-6; (1000,-7) -> quot=-142, rem=6; (-1000,-7) -> quot=142, rem=-6.
REQ-033 SHALL cover: din2=0, din1=5 -> quot=0, rem=0, dz=1, done at cycle 27.
REQ-034 SHALL cover: din1=-33554432, din2=-1 -> quot=-33554432, rem=0, ovf=1; also din1=-33554432, din2=-4096 -> quot=8192, rem=0, ovf=0.
REQ-035 SHALL cover: start reasserted with new operands at cycles 5 and 27 of a busy run -> ignored, first result unchanged, busy falls after the single done.
REQ-036 SHALL cover: rst pulled low at cycle 10 of a run -> all outputs 0 immediately, no done; next start completes normally with correct result.
